// File: rtl/pc_fetch_register.sv
// pc_fetch_register
// -----------------
// Program counter and fetch stage for a strictly linear program. The current
// index goes out to the external incrementer and to instruction memory; the
// incremented value comes back and is loaded on every issued fetch. Returned
// instructions land in a 2-entry FIFO that decode drains with valid/ready.
// After LAST_INDEX has been issued no further fetches happen, and halt rises
// once the outstanding read and the buffer have both drained.
//
// Ports:
//   clk                          system clock, rising edge
//   reset                        asynchronous, active-high reset
//   instruction_input_index_old  current PC (incrementer input, imem address)
//   instruction_input_index_new  incremented PC from the incrementer
//   imem_rd_en                   read strobe to instruction memory
//   imem_rdata                   memory data, valid the cycle after the strobe
//   stall                        blocks issue of new fetches
//   instr_valid                  buffer head holds an instruction
//   instr_data                   buffer-head instruction word
//   instr_index                  index the head instruction was fetched from
//   instr_ready                  decode accepts the head when valid && ready
//   halt                         program finished and buffer drained
module pc_fetch_register #(
    parameter int                ADDR_W      = 8,
    parameter int                INSTR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_INDEX = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] LAST_INDEX  = {ADDR_W{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  instruction_input_index_old,
    input  logic [ADDR_W-1:0]  instruction_input_index_new,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_index,
    input  logic               instr_ready,
    output logic               halt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_in_flight;
    logic [ADDR_W-1:0]   r_fetch_idx;
    logic [INSTR_W-1:0]  r_buf_data [2];
    logic [ADDR_W-1:0]   r_buf_idx  [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic [2:0]          w_occ;

    assign w_pop  = (r_count != 2'd0) && instr_ready;
    assign w_push = r_in_flight;
    assign w_occ  = {1'b0, r_count} + {2'b00, r_in_flight};

    // Issue while running, unstalled, and the buffer plus the outstanding read
    // (net of this cycle's pop) still leaves room. Written as occ < 2 + pop to
    // keep the unsigned arithmetic free of underflow. Reset gates the strobe
    // so it drops immediately on an asynchronous assert.
    assign w_issue = !reset && (r_state == ST_RUN) && !stall
                     && (w_occ < (3'd2 + {2'b00, w_pop}));

    assign imem_rd_en                  = w_issue;
    assign instruction_input_index_old = r_pc;
    assign instr_valid                 = (r_count != 2'd0);
    assign instr_data                  = r_buf_data[r_rd_ptr];
    assign instr_index                 = r_buf_idx[r_rd_ptr];
    assign halt                        = (r_state == ST_HALTED);

    // Next-state logic for the run / drain / halted sequencing.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_issue && (r_pc == LAST_INDEX)) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!r_in_flight && (r_count == 2'd0)) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC load and outstanding-read tracking; the fetched index travels with
    // the read so it can be paired with the returning data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_INDEX;
            r_in_flight <= 1'b0;
            r_fetch_idx <= {ADDR_W{1'b0}};
        end else begin
            r_in_flight <= w_issue;
            if (w_issue) begin
                r_pc        <= instruction_input_index_new;
                r_fetch_idx <= r_pc;
            end
        end
    end

    // Buffer storage: returned data is written the edge after issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_data[0] <= {INSTR_W{1'b0}};
            r_buf_data[1] <= {INSTR_W{1'b0}};
            r_buf_idx[0]  <= {ADDR_W{1'b0}};
            r_buf_idx[1]  <= {ADDR_W{1'b0}};
        end else if (w_push) begin
            r_buf_data[r_wr_ptr] <= imem_rdata;
            r_buf_idx[r_wr_ptr]  <= r_fetch_idx;
        end
    end

    // Buffer pointers and occupancy; push and pop together leave count as is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_register.sv
`timescale 1ns/1ps
// Bench for pc_fetch_register. Three instances cover the default program,
// LAST_INDEX = 4 and a wrapping program FE..01. Each has a bench-side
// incrementer and a one-cycle-latency memory returning {~index, index}.
// A scoreboard queues the expected {data, index} on every observed fetch
// (using the bench's own expected PC) and checks every accepted instruction.
module tb_pc_fetch_register;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic        stall;
    logic        ready;
    logic [7:0]  pc_old [3];
    logic [7:0]  pc_new [3];
    logic [7:0]  idx_o  [3];
    logic [15:0] rdata  [3];
    logic [15:0] data_o [3];
    logic        rd_en  [3];
    logic        valid  [3];
    logic        halt_o [3];

    int          n_checks = 0;
    int          n_errors = 0;
    int          sel      = 0;
    logic        mon_en   = 1'b0;
    logic [7:0]  exp_pc   = 8'h00;
    logic [23:0] sb [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pc_fetch_register #(
            .ADDR_W     (8),
            .INSTR_W    (16),
            .RESET_INDEX((g == 2) ? 8'hFE : 8'h00),
            .LAST_INDEX ((g == 0) ? 8'hFF : ((g == 1) ? 8'h04 : 8'h01))
        ) u_dut (
            .clk                        (clk),
            .reset                      (rst[g]),
            .instruction_input_index_old(pc_old[g]),
            .instruction_input_index_new(pc_new[g]),
            .imem_rd_en                 (rd_en[g]),
            .imem_rdata                 (rdata[g]),
            .stall                      (stall),
            .instr_valid                (valid[g]),
            .instr_data                 (data_o[g]),
            .instr_index                (idx_o[g]),
            .instr_ready                (ready),
            .halt                       (halt_o[g])
        );

        assign pc_new[g] = pc_old[g] + 8'd1;

        always @(posedge clk) begin
            if (rd_en[g]) rdata[g] <= {~pc_old[g], pc_old[g]};
        end
    end

    // Scoreboard monitor for the instance currently under test.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst[sel]) begin
                if (rd_en[sel]) begin
                    n_checks++;
                    if (pc_old[sel] !== exp_pc) begin
                        n_errors++;
                        $display("FAIL fetch_addr: got %h want %h", pc_old[sel], exp_pc);
                    end
                    sb.push_back({~exp_pc, exp_pc, exp_pc});
                    exp_pc = exp_pc + 8'd1;
                end
                if (valid[sel] && ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_unexpected: got idx %h data %h want nothing", idx_o[sel], data_o[sel]);
                    end else begin
                        e = sb.pop_front();
                        if ({data_o[sel], idx_o[sel]} !== e) begin
                            n_errors++;
                            $display("FAIL sb_pop: got %h want %h", {data_o[sel], idx_o[sel]}, e);
                        end
                    end
                end
            end
        end
    end

    task automatic start_dut(input int g);
        rst    = 3'b111;
        stall  = 1'b0;
        ready  = 1'b1;
        sel    = g;
        sb.delete();
        exp_pc = (g == 2) ? 8'hFE : 8'h00;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst[g] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({rd_en[0], valid[0], halt_o[0]} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags: got %b want 000", {rd_en[0], valid[0], halt_o[0]});
        end
        n_checks++;
        if ({data_o[0], idx_o[0]} !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_head: got %h want 000000", {data_o[0], idx_o[0]});
        end
        n_checks++;
        if (pc_old[0] !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_pc: got %h want 00", pc_old[0]);
        end
    endtask

    // Default instance, ready held high: one fetch and (from cycle 2) one
    // delivery per cycle. Ends at the start of cycle 5, head = index 3.
    task automatic test_stream();
        start_dut(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (rd_en[0] !== 1'b1 || pc_old[0] !== 8'(k)) begin
                n_errors++;
                $display("FAIL stream_issue: got en %b pc %h want en 1 pc %h", rd_en[0], pc_old[0], 8'(k));
            end
            n_checks++;
            if (valid[0] !== (k >= 2)) begin
                n_errors++;
                $display("FAIL stream_valid: got %b want %b at cycle %0d", valid[0], (k >= 2), k);
            end
            if (k >= 2) begin
                n_checks++;
                if (idx_o[0] !== 8'(k - 2)) begin
                    n_errors++;
                    $display("FAIL stream_index: got %h want %h", idx_o[0], 8'(k - 2));
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        n_checks++;
        if (valid[0] !== 1'b1 || idx_o[0] !== 8'h03) begin
            n_errors++;
            $display("FAIL bp_start: got valid %b idx %h want 1 03", valid[0], idx_o[0]);
        end
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (rd_en[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_issue: got %b want 0 at cycle %0d", rd_en[0], i);
            end
            n_checks++;
            if (valid[0] !== 1'b1 || {data_o[0], idx_o[0]} !== 24'hFC0303) begin
                n_errors++;
                $display("FAIL bp_hold: got %b %h want 1 fc0303", valid[0], {data_o[0], idx_o[0]});
            end
            @(posedge clk); #1;
        end
        ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (valid[0] !== 1'b1 || idx_o[0] !== 8'(3 + i)) begin
                n_errors++;
                $display("FAIL bp_release: got %b %h want 1 %h", valid[0], idx_o[0], 8'(3 + i));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        bit seen6 = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (pc_old[0] == 8'h07) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL stall_find_pc7: got %h want 07 within 10 cycles", pc_old[0]);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (rd_en[0] !== 1'b0 || pc_old[0] !== 8'h07) begin
                n_errors++;
                $display("FAIL stall_hold: got en %b pc %h want 0 07", rd_en[0], pc_old[0]);
            end
            if (valid[0] && idx_o[0] == 8'h06) seen6 = 1'b1;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        n_checks++;
        if (!seen6) begin
            n_errors++;
            $display("FAIL stall_inflight: got no index 06 want 06 delivered");
        end
        @(negedge clk);
        n_checks++;
        if (rd_en[0] !== 1'b1 || pc_old[0] !== 8'h07) begin
            n_errors++;
            $display("FAIL stall_resume: got en %b pc %h want 1 07", rd_en[0], pc_old[0]);
        end
    endtask

    // Reset mid-cycle with the buffer occupied and a read outstanding.
    task automatic test_async_reset();
        repeat (3) @(posedge clk);
        #2;
        rst[0] = 1'b1;
        sb.delete();
        exp_pc = 8'h00;
        #1;
        n_checks++;
        if ({valid[0], rd_en[0], halt_o[0]} !== 3'b000 || {data_o[0], idx_o[0]} !== 24'h0) begin
            n_errors++;
            $display("FAIL areset_outputs: got %b %h want 000 000000", {valid[0], rd_en[0], halt_o[0]}, {data_o[0], idx_o[0]});
        end
        @(posedge clk); #1;
        rst[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (rd_en[0] !== 1'b1 || pc_old[0] !== 8'(k)) begin
                n_errors++;
                $display("FAIL areset_refetch: got en %b pc %h want 1 %h", rd_en[0], pc_old[0], 8'(k));
            end
            n_checks++;
            if (valid[0] !== (k >= 2)) begin
                n_errors++;
                $display("FAIL areset_valid: got %b want %b at cycle %0d", valid[0], (k >= 2), k);
            end
        end
    endtask

    task automatic test_last();
        int n_rd = 0, n_pop = 0, last_pop = -1, halt_cyc = -1;
        start_dut(1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_en[1]) n_rd++;
            if (valid[1] && ready) begin n_pop++; last_pop = c; end
            if (halt_o[1] && halt_cyc < 0) halt_cyc = c;
        end
        n_checks++;
        if (n_rd != 5) begin
            n_errors++;
            $display("FAIL last_fetch_count: got %0d want 5", n_rd);
        end
        n_checks++;
        if (n_pop != 5) begin
            n_errors++;
            $display("FAIL last_pop_count: got %0d want 5", n_pop);
        end
        n_checks++;
        if (halt_cyc != last_pop + 2 || halt_o[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL last_halt: got halt cycle %0d want %0d", halt_cyc, last_pop + 2);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got   [8];
        logic [7:0] exp_w [4];
        int n = 0, n_rd = 0;
        exp_w[0] = 8'hFE; exp_w[1] = 8'hFF; exp_w[2] = 8'h00; exp_w[3] = 8'h01;
        start_dut(2);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_en[2]) n_rd++;
            if (valid[2] && ready && n < 8) begin got[n] = idx_o[2]; n++; end
        end
        n_checks++;
        if (n != 4 || n_rd != 4) begin
            n_errors++;
            $display("FAIL wrap_count: got pops %0d fetches %0d want 4 4", n, n_rd);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            n_checks++;
            if (got[i] !== exp_w[i]) begin
                n_errors++;
                $display("FAIL wrap_order: got %h want %h at %0d", got[i], exp_w[i], i);
            end
        end
        n_checks++;
        if (halt_o[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_halt: got %b want 1", halt_o[2]);
        end
    endtask

    initial begin
        rst   = 3'b111;
        stall = 1'b0;
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_async_reset();
        test_last();
        test_wrap();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
